// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: write port of the 4-bit frame buffer RAM.
// The block turns a raster-ordered valid/ready pixel stream into registered
// RAM write strobes. It also has a full-frame clear engine that fills every
// location with a single colour.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | stream mode, s_ready_o=1, beats written at the pointer
//   ST_CLEAR | fill mode, one location per cycle at the latched colour
module fb_pixel_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_sof_i,
  input  logic              clear_req_i,
  input  logic [DATA_W-1:0] clear_color_i,
  output logic              busy_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              frame_done_o,
  output logic              sof_error_o
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0]     X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(V_RES - 1);
  localparam logic [ADDR_W-1:0] P_LAST = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic {ST_RUN, ST_CLEAR} state_e;

  state_e              state_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [DATA_W-1:0]   color_q;
  logic                busy_q;

  // Location of the current beat. A start-of-frame marker forces it to 0.
  logic [XW-1:0]       base_x;
  logic [YW-1:0]       base_y;
  logic [ADDR_W-1:0]   base_ptr;
  logic [XW-1:0]       x_d;
  logic [YW-1:0]       y_d;
  logic [ADDR_W-1:0]   ptr_d;
  logic                last_d;
  logic                accept;

  // Ready depends only on the state. It is held low while reset is asserted.
  assign s_ready_o = rst_n_i && (state_q == ST_RUN);
  assign accept    = s_valid_i && s_ready_o;
  assign busy_o    = busy_q;

  // Advance the raster pointer past the current beat. The x/y counters
  // track line wrap, so the linear address needs no multiplier.
  always_comb begin
    base_x   = s_sof_i ? '0 : x_q;
    base_y   = s_sof_i ? '0 : y_q;
    base_ptr = s_sof_i ? '0 : ptr_q;
    x_d      = base_x + 1'b1;
    y_d      = base_y;
    ptr_d    = base_ptr + 1'b1;
    last_d   = 1'b0;
    if (base_x == X_LAST) begin
      x_d = '0;
      if (base_y == Y_LAST) begin
        y_d    = '0;
        ptr_d  = '0;
        last_d = 1'b1;
      end else begin
        y_d = base_y + 1'b1;
      end
    end
  end

  // Run/clear FSM with registered write strobes and status pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_RUN;
      x_q          <= '0;
      y_q          <= '0;
      ptr_q        <= '0;
      color_q      <= '0;
      busy_q       <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      frame_done_o <= 1'b0;
      sof_error_o  <= 1'b0;
    end else begin
      wr_en_o      <= 1'b0;
      frame_done_o <= 1'b0;
      sof_error_o  <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            wr_en_o      <= 1'b1;
            wr_addr_o    <= base_ptr;
            wr_data_o    <= s_data_i;
            frame_done_o <= last_d;
            sof_error_o  <= s_sof_i && (ptr_q != '0);
            x_q          <= x_d;
            y_q          <= y_d;
            ptr_q        <= ptr_d;
          end
          // A beat accepted on this edge is written before the clear starts.
          // The pointer is then reused as the clear address.
          if (clear_req_i) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            color_q <= clear_color_i;
            x_q     <= '0;
            y_q     <= '0;
            ptr_q   <= '0;
          end
        end
        ST_CLEAR: begin
          wr_en_o   <= 1'b1;
          wr_addr_o <= ptr_q;
          wr_data_o <= color_q;
          if (ptr_q == P_LAST) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
module tb_fb_pixel_writer;

  logic clk;
  logic rst_n;

  // Full-size instance (640x480)
  logic        b_valid, b_sof, b_clr, b_ready, b_busy, b_we, b_fd, b_se;
  logic [3:0]  b_data, b_col, b_wdata;
  logic [18:0] b_addr;

  // Small instance (4x2)
  logic        s_valid, s_sof, s_clr, s_ready, s_busy, s_we, s_fd, s_se;
  logic [3:0]  s_data, s_col, s_wdata;
  logic [18:0] s_addr;

  int checks = 0;
  int errors = 0;

  fb_pixel_writer #(.H_RES(640), .V_RES(480), .ADDR_W(19), .DATA_W(4)) dut_big (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(b_valid), .s_ready_o(b_ready),
    .s_data_i(b_data), .s_sof_i(b_sof), .clear_req_i(b_clr), .clear_color_i(b_col),
    .busy_o(b_busy), .wr_en_o(b_we), .wr_addr_o(b_addr), .wr_data_o(b_wdata),
    .frame_done_o(b_fd), .sof_error_o(b_se));

  fb_pixel_writer #(.H_RES(4), .V_RES(2), .ADDR_W(19), .DATA_W(4)) dut_small (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .s_sof_i(s_sof), .clear_req_i(s_clr), .clear_color_i(s_col),
    .busy_o(s_busy), .wr_en_o(s_we), .wr_addr_o(s_addr), .wr_data_o(s_wdata),
    .frame_done_o(s_fd), .sof_error_o(s_se));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        sof;
    logic        clr;
    logic [3:0]  col;
    logic        e_we;
    logic [18:0] e_addr;
    logic [3:0]  e_data;
    logic        e_fd;
    logic        e_se;
    logic        e_busy;
    logic        e_rdy;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [3:0] d, input logic sof, input logic clr,
                     input logic [3:0] col, input logic we, input logic [18:0] addr,
                     input logic [3:0] data, input logic fd, input logic se,
                     input logic busy, input logic rdy);
    vec_t t;
    t = '{v, d, sof, clr, col, we, addr, data, fd, se, busy, rdy};
    tv.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic found;

    // Vector table for the 4x2 instance, applied in order after reset.
    // A: two continuous frames, sof on the first beat
    for (int i = 0; i < 16; i++)
      add(1'b1, 4'(i), i == 0, 1'b0, 4'h0,
          1'b1, 19'(i % 8), 4'(i), (i % 8) == 7, 1'b0, 1'b0, 1'b1);
    // B: sof on the 4th beat, mid-frame
    for (int i = 0; i < 11; i++)
      add(1'b1, 4'(i + 1), i == 3, 1'b0, 4'h0,
          1'b1, (i < 3) ? 19'(i) : (i == 3) ? 19'd0 : 19'(i - 3),
          4'(i + 1), i == 10, i == 3, 1'b0, 1'b1);
    // C: clear request together with a beat at ptr=2
    add(1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 1'b1, 19'd0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'h6, 1'b0, 1'b0, 4'h0, 1'b1, 19'd1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'h3, 1'b0, 1'b1, 4'hA, 1'b1, 19'd2, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      add(1'b0, 4'h0, 1'b0, k == 2, (k == 2) ? 4'h5 : 4'h0,
          1'b1, 19'(k), 4'hA, 1'b0, 1'b0, k != 7, k == 7);
    add(1'b1, 4'h9, 1'b0, 1'b0, 4'h0, 1'b1, 19'd0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 19'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    // D: s_valid held high through a clear; the held beat lands at addr 0
    add(1'b1, 4'h1, 1'b0, 1'b1, 4'h7, 1'b1, 19'd1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      add(1'b1, 4'h2, 1'b0, 1'b0, 4'h0,
          1'b1, 19'(k), 4'h7, 1'b0, 1'b0, k != 7, k == 7);
    add(1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b1, 19'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4'h4, 1'b0, 1'b0, 4'h0, 1'b1, 19'd1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0;
    b_valid = 0; b_sof = 0; b_clr = 0; b_data = 0; b_col = 0;
    s_valid = 0; s_sof = 0; s_clr = 0; s_data = 0; s_col = 0;
    repeat (3) step();

    // Reset values
    chk("rst_big_we",    b_we,    0);
    chk("rst_big_addr",  b_addr,  0);
    chk("rst_big_data",  b_wdata, 0);
    chk("rst_big_busy",  b_busy,  0);
    chk("rst_big_ready", b_ready, 0);
    chk("rst_small_fd",  s_fd,    0);
    chk("rst_small_se",  s_se,    0);
    chk("rst_small_ready", s_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_big_ready", b_ready, 1);
    chk("rel_small_ready", s_ready, 1);

    // Full-size line: 640 beats, data i%16, sof on the first
    for (int i = 0; i < 640; i++) begin
      b_valid = 1'b1;
      b_data  = 4'(i % 16);
      b_sof   = (i == 0);
      step();
      chk($sformatf("big%0d_we", i),   b_we,    1);
      chk($sformatf("big%0d_addr", i), b_addr,  32'(i));
      chk($sformatf("big%0d_data", i), b_wdata, 32'(i % 16));
      chk($sformatf("big%0d_fd", i),   b_fd,    0);
      chk($sformatf("big%0d_se", i),   b_se,    0);
    end
    b_valid = 1'b0;
    b_sof   = 1'b0;
    step();
    chk("big_idle_we", b_we, 0);

    // Table-driven 4x2 vectors
    foreach (tv[i]) begin
      s_valid = tv[i].v;
      s_data  = tv[i].d;
      s_sof   = tv[i].sof;
      s_clr   = tv[i].clr;
      s_col   = tv[i].col;
      step();
      chk($sformatf("v%0d_we", i), s_we, tv[i].e_we);
      if (tv[i].e_we) begin
        chk($sformatf("v%0d_addr", i), s_addr,  tv[i].e_addr);
        chk($sformatf("v%0d_data", i), s_wdata, tv[i].e_data);
      end
      chk($sformatf("v%0d_fd", i),    s_fd,    tv[i].e_fd);
      chk($sformatf("v%0d_se", i),    s_se,    tv[i].e_se);
      chk($sformatf("v%0d_busy", i),  s_busy,  tv[i].e_busy);
      chk($sformatf("v%0d_ready", i), s_ready, tv[i].e_rdy);
    end
    s_valid = 1'b0;
    s_clr   = 1'b0;

    // Reset dropped mid-clear once address 3 has been presented
    s_clr = 1'b1;
    s_col = 4'hC;
    step();
    s_clr = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (s_we && s_addr == 19'd3) found = 1'b1;
    end
    chk("midclr_reach_addr3", found, 1);
    chk("midclr_data", s_wdata, 4'hC);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we",    s_we,    0);
    chk("arst_addr",  s_addr,  0);
    chk("arst_data",  s_wdata, 0);
    chk("arst_busy",  s_busy,  0);
    chk("arst_ready", s_ready, 0);
    step();
    chk("arst_hold_we", s_we, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", s_ready, 1);
    s_valid = 1'b1;
    s_data  = 4'hE;
    step();
    s_valid = 1'b0;
    chk("post_rst_we",   s_we,    1);
    chk("post_rst_addr", s_addr,  0);
    chk("post_rst_data", s_wdata, 4'hE);
    chk("post_rst_busy", s_busy,  0);
    step();
    chk("post_rst_idle", s_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
